// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM sequencing the shared multi-cycle RISC-V datapath.
// Optional macro ILLEGAL_TRAP_EN: unsupported opcodes park in TRAP with illegal_op raised.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] OP,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic       instr_done
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic       illegal_op
`endif
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
`ifdef ILLEGAL_TRAP_EN
  localparam logic [3:0] S_TRAP     = 4'd11;
`endif

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  logic [STATE_W-1:0] state_q, state_d;
  logic op_known;
  logic pc_update, branch, mem_write, ir_write, reg_write, done;

  assign op_known = (OP == OP_LW) || (OP == OP_SW) || (OP == OP_R) ||
                    (OP == OP_I) || (OP == OP_BEQ) || (OP == OP_JAL);

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (!op_known) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_FETCH;
`endif
        end else begin
          case (OP)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_R:         state_d = S_EXECUTER;
            OP_I:         state_d = S_EXECUTEI;
            OP_BEQ:       state_d = S_BEQ;
            default:      state_d = S_JAL;
          endcase
        end
      end
      S_MEMADR:   state_d = (OP == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    pc_update = 1'b0;
    branch    = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    done      = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_write = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; pc_update = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b01;
`ifndef ILLEGAL_TRAP_EN
        // Unknown opcode retires here as a NOP.
        done = ~op_known;
`endif
      end
      S_MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB:    begin ResultSrc = 2'b01; reg_write = 1'b1; done = 1'b1; end
      S_MEMWRITE: begin AdrSrc = 1'b1; mem_write = 1'b1; done = 1'b1; end
      S_EXECUTER: begin ALUSrcA = 2'b10; ALUSrcB = 2'b00; ALUOp = 2'b10; end
      S_EXECUTEI: begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUOp = 2'b10; end
      S_ALUWB:    begin reg_write = 1'b1; done = 1'b1; end
      S_JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; pc_update = 1'b1; end
      S_BEQ: begin
        ALUSrcA = 2'b10; ALUOp = 2'b01; branch = 1'b1; done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (OP)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Reset parks the FSM in FETCH asynchronously; enables are additionally masked while it is held.
  assign PCWrite    = ~rst & (pc_update | (branch & Zero));
  assign IRWrite    = ~rst & ir_write;
  assign MemWrite   = ~rst & mem_write;
  assign RegWrite   = ~rst & reg_write;
  assign instr_done = ~rst & done;
`ifdef ILLEGAL_TRAP_EN
  assign illegal_op = (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized per-cycle check of every control output against a step-table model.
module tb_multicycle_controller;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  logic clk = 1'b0, rst = 1'b1, Zero = 1'b0;
  logic [6:0] OP = LW;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, ill_w;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  int total = 0, bad = 0;
  logic [16:0] got_w [1:8];
  logic [16:0] exp_w [1:8];
  int n_steps;

  always #5 clk = ~clk;

`ifdef ILLEGAL_TRAP_EN
  logic illegal_op;
  assign ill_w = illegal_op;
`else
  assign ill_w = 1'b0;
`endif

  multicycle_controller dut (
    .clk(clk), .rst(rst), .OP(OP), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .RegWrite(RegWrite), .ImmSrc(ImmSrc), .instr_done(instr_done)
`ifdef ILLEGAL_TRAP_EN
    , .illegal_op(illegal_op)
`endif
  );

  // Word layout: pcw adr memw irw res[2] srca[2] srcb[2] aluop[2] regw imm[2] done ill
  function automatic logic [16:0] dut_word();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
            RegWrite, ImmSrc, instr_done, ill_w};
  endfunction

  function automatic bit legal(input logic [6:0] op);
    return op == LW || op == SW || op == RT || op == IT || op == BQ || op == JL;
  endfunction

  function automatic int latency(input logic [6:0] op);
    case (op)
      LW: return 5;
      BQ: return 3;
      SW, RT, IT, JL: return 4;
      default: return TRAP_EN ? 6 : 2;
    endcase
  endfunction

  // Expected outputs for cycle `step` (1 = fetch) of instruction `op`, with `op_now` on the OP pins.
  function automatic logic [16:0] model(input logic [6:0] op, input logic [6:0] op_now,
                                        input int step, input logic z);
    logic pcw, adr, mw, irw, rw, dn, il;
    logic [1:0] res, sa, sb, ao, imm;
    {pcw, adr, mw, irw, rw, dn, il} = '0;
    {res, sa, sb, ao} = '0;
    imm = (op_now == SW) ? 2'b01 : (op_now == BQ) ? 2'b10 : (op_now == JL) ? 2'b11 : 2'b00;
    if (step == 1) begin
      irw = 1; sb = 2'b10; res = 2'b10; pcw = 1;
    end else if (step == 2) begin
      sa = 2'b01; sb = 2'b01; dn = !TRAP_EN && !legal(op);
    end else if (!legal(op)) begin
      il = 1'b1;
    end else if (op == BQ) begin
      sa = 2'b10; ao = 2'b01; pcw = z; dn = 1;
    end else if (step == latency(op)) begin
      dn = 1;
      if (op == SW) begin adr = 1; mw = 1; end
      else begin rw = 1; res = (op == LW) ? 2'b01 : 2'b00; end
    end else if (step == 3) begin
      case (op)
        RT:      begin sa = 2'b10; sb = 2'b00; ao = 2'b10; end
        IT:      begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
        JL:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
        default: begin sa = 2'b10; sb = 2'b01; end
      endcase
    end else begin
      adr = 1;
    end
    return {pcw, adr, mw, irw, res, sa, sb, ao, rw, imm, dn, il};
  endfunction

  // Runs one instruction from mid-FETCH; zforce<0 randomizes Zero, perturb scrambles OP in unsampled cycles.
  task automatic run_instr(input logic [6:0] op, input int zforce, input bit perturb);
    logic [6:0] op_now;
    n_steps = latency(op);
    for (int s = 1; s <= n_steps; s++) begin
      op_now = op;
      if (perturb && (s == 1 || s >= 4)) op_now = 7'($urandom);
      OP = op_now;
      Zero = (zforce >= 0 && s == 3) ? zforce[0] : 1'($urandom);
      #1;
      got_w[s] = dut_word();
      exp_w[s] = model(op, op_now, s, Zero);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [16:0] want;
    rst = 1; OP = LW; Zero = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0; #1;
    total++;
    if (dut_word() !== model(LW, LW, 1, 0)) begin
      bad++; $display("FAIL reset_release got=%b want=%b", dut_word(), model(LW, LW, 1, 0));
    end
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (AdrSrc !== 1'b1) begin bad++; $display("FAIL reached_memread AdrSrc got=%b want=1", AdrSrc); end
    #1 rst = 1; #1;
    want = {1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0};
    total++;
    if (dut_word() !== want) begin bad++; $display("FAIL async_reset got=%b want=%b", dut_word(), want); end
    @(posedge clk); #1;
    total++;
    if (dut_word() !== want) begin bad++; $display("FAIL reset_held got=%b want=%b", dut_word(), want); end
    @(negedge clk); rst = 0; #1;
    total++;
    if (dut_word() !== model(LW, LW, 1, 0)) begin
      bad++; $display("FAIL reset_fetch got=%b want=%b", dut_word(), model(LW, LW, 1, 0));
    end
  endtask

  task automatic test_lw();
    run_instr(LW, -1, 0);
    for (int s = 1; s <= n_steps; s++) begin
      total++;
      if (got_w[s] !== exp_w[s]) begin bad++; $display("FAIL lw step%0d got=%b want=%b", s, got_w[s], exp_w[s]); end
    end
  endtask

  task automatic test_sw();
    run_instr(SW, -1, 0);
    for (int s = 1; s <= n_steps; s++) begin
      total++;
      if (got_w[s] !== exp_w[s]) begin bad++; $display("FAIL sw step%0d got=%b want=%b", s, got_w[s], exp_w[s]); end
    end
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      run_instr(BQ, z, 0);
      for (int s = 1; s <= n_steps; s++) begin
        total++;
        if (got_w[s] !== exp_w[s])
          begin bad++; $display("FAIL beq_z%0d step%0d got=%b want=%b", z, s, got_w[s], exp_w[s]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] seq [3];
    seq = '{RT, IT, JL};
    for (int k = 0; k < 3; k++) begin
      run_instr(seq[k], -1, 0);
      for (int s = 1; s <= n_steps; s++) begin
        total++;
        if (got_w[s] !== exp_w[s])
          begin bad++; $display("FAIL b2b_op%b step%0d got=%b want=%b", seq[k], s, got_w[s], exp_w[s]); end
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [6];
    logic [6:0] op;
    ops = '{LW, SW, RT, IT, BQ, JL};
    for (int k = 0; k < 40; k++) begin
      op = ops[$urandom_range(5, 0)];
      run_instr(op, -1, 1);
      for (int s = 1; s <= n_steps; s++) begin
        total++;
        if (got_w[s] !== exp_w[s])
          begin bad++; $display("FAIL rand%0d_op%b step%0d got=%b want=%b", k, op, s, got_w[s], exp_w[s]); end
      end
    end
  endtask

  task automatic test_illegal();
    run_instr(BAD, -1, 0);
    for (int s = 1; s <= n_steps; s++) begin
      total++;
      if (got_w[s] !== exp_w[s]) begin bad++; $display("FAIL illegal step%0d got=%b want=%b", s, got_w[s], exp_w[s]); end
    end
    // Whichever build, a fresh lw after this must start cleanly (from reset if trapped).
    if (TRAP_EN) begin
      #1 rst = 1; @(negedge clk); rst = 0;
    end
    run_instr(LW, -1, 0);
    for (int s = 1; s <= n_steps; s++) begin
      total++;
      if (got_w[s] !== exp_w[s]) begin bad++; $display("FAIL post_illegal step%0d got=%b want=%b", s, got_w[s], exp_w[s]); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_beq();
    test_back_to_back();
    test_random();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Moore control FSM that sequences the shared multi-cycle RISC-V datapath: one memory, one ALU, and the IR/PC/ALUOut registers reused across several cycles per instruction. Decodes OP in DECODE and drives mux selects and write enables cycle by cycle. Supports lw, sw, R-type, I-type ALU, beq and jal. Sits beside the ALU decoder, which consumes ALUOp.

Parameters:
STATE_W, 4, state register width; fixed at 4, 11 states used.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
OP  input  7  opcode field from IR (instr[6:0])
Zero  input  1  ALU zero flag
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut
MemWrite  output  1  data memory write enable
IRWrite  output  1  instruction register enable
ResultSrc  output  2  result mux: 00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  output  2  ALU A: 00=PC, 01=OldPC, 10=RD1
ALUSrcB  output  2  ALU B: 00=RD2, 01=ImmExt, 10=constant 4
ALUOp  output  2  to ALU decoder: 00=add, 01=sub, 10=funct-decoded
RegWrite  output  1  register file write enable
ImmSrc  output  2  immediate format: 00=I, 01=S, 10=B, 11=J
instr_done  output  1  one-cycle pulse in the final state of each instruction

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous and active-high. rst forces state to FETCH immediately, independent of clk.
- While rst is high, PCWrite, IRWrite, MemWrite, RegWrite and instr_done are forced to 0. All other outputs take their FETCH values.
- After release, the first rising edge is spent in FETCH.
- Default value of every output not listed for a state is 0.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next state DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by OP:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - other -> see Optional Feature
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state MEMREAD if OP=lw, else MEMWRITE.
- MEMREAD: AdrSrc=1. Next state MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, instr_done=1. Next state FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1, instr_done=1. Next state FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_done=1. Next state FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next state ALUWB.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, instr_done=1. Next state FETCH.
- PCWrite = PCUpdate | (Branch & Zero). This is the only output that depends combinationally on Zero.
- ImmSrc is decoded combinationally from OP in every state:
  - sw -> 01
  - beq -> 10
  - jal -> 11
  - all others -> 00
- Latency in cycles: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3.
- OP is sampled only in DECODE and MEMADR. The IR is stable after FETCH, so changes on OP in other states have no effect on transitions.
- Unused state encodings transition to FETCH with all enables 0.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: an unsupported OP in DECODE moves to state TRAP, and output illegal_op (1 bit, reset 0) goes high.
  - TRAP drives every enable to 0 and holds indefinitely; only rst exits it.
  - illegal_op stays high while in TRAP.
- Undefined: no illegal_op port and no TRAP state. An unsupported OP in DECODE returns to FETCH with instr_done=1, so the instruction executes as a 2-cycle NOP with no register or memory write.

Test Plan:
- Reset: rst=1 asynchronously mid-MEMREAD -> same cycle PCWrite=IRWrite=RegWrite=MemWrite=0; after release, state FETCH with IRWrite=1, ALUSrcB=10.
- lw (OP=0000011) -> states F,D,MEMADR,MEMREAD,MEMWB; RegWrite=1 and ResultSrc=01 only in cycle 5; instr_done pulses in cycle 5 only.
- sw (OP=0100011) -> MemWrite=1 and AdrSrc=1 only in cycle 4; ImmSrc=01 throughout; RegWrite never asserted.
- beq (OP=1100011), Zero=1 in cycle 3 -> PCWrite=1 and ALUOp=01 in cycle 3. Repeat with Zero=0 -> PCWrite=0 in cycle 3. Next FETCH in cycle 4 in both cases.
- R-type (0110011), then addi (0010011), then jal (1101111) back-to-back -> each takes 4 cycles. ALUOp=10 in cycle 3 for R-type and addi. jal asserts PCWrite in cycles 1 and 3 with ImmSrc=11. All three end in ALUWB with RegWrite=1.
- OP=1111111 -> with ILLEGAL_TRAP_EN: illegal_op=1 from cycle 3, all enables 0 until rst. Without it: FETCH in cycle 3, instr_done=1 in cycle 2, no RegWrite or MemWrite.
